// File: rtl/alu_cmd_ctrl.sv
// Command front-end for the 32-bit combinational ALU: a 4-entry operand register file,
// a one-cycle issue slot for the ALU and a held valid/ready response channel.
module alu_cmd_ctrl #(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [3:0]       cmd_f,
    input  logic [1:0]       cmd_rd,
    input  logic [1:0]       cmd_rs1,
    input  logic [1:0]       cmd_rs2,
    input  logic [W-1:0]     cmd_imm,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_data,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [3:0]       alu_f,
    input  logic [W-1:0]     alu_r,
    output logic [CNT_W-1:0] exec_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_EXEC = 2'd1;
    localparam logic [1:0] OP_READ = 2'd2;
    localparam logic [1:0] OP_NOP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [W-1:0]     regs_q [4];
    logic [W-1:0]     regs_d [4];
    logic [W-1:0]     alu_a_q, alu_a_d;
    logic [W-1:0]     alu_b_q, alu_b_d;
    logic [3:0]       alu_f_q, alu_f_d;
    logic [1:0]       rd_q, rd_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [W-1:0]     rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0] exec_count_q, exec_count_d;
    logic             accept;

    assign cmd_ready = (state_q == IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d      = state_q;
        regs_d       = regs_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_f_d      = alu_f_q;
        rd_d         = rd_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        exec_count_d = exec_count_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_LOAD: regs_d[cmd_rd] = cmd_imm;
                        // Operands are captured here, so rd aliasing rs1/rs2 is harmless.
                        OP_EXEC: begin
                            alu_a_d = regs_q[cmd_rs1];
                            alu_b_d = regs_q[cmd_rs2];
                            alu_f_d = cmd_f;
                            rd_d    = cmd_rd;
                            state_d = ISSUE;
                        end
                        OP_READ: begin
                            rsp_data_d  = regs_q[cmd_rs1];
                            rsp_valid_d = 1'b1;
                            state_d     = RESP;
                        end
                        OP_NOP:  state_d = IDLE;
                        default: state_d = IDLE;
                    endcase
                end
            end
            // The ALU has had a full cycle on registered operands; commit its result.
            ISSUE: begin
                regs_d[rd_q] = alu_r;
                rsp_data_d   = alu_r;
                rsp_valid_d  = 1'b1;
                exec_count_d = exec_count_q + CNT_W'(1);
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_f_q      <= '0;
            rd_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            exec_count_q <= '0;
        end else begin
            state_q      <= state_d;
            regs_q       <= regs_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_f_q      <= alu_f_d;
            rd_q         <= rd_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            exec_count_q <= exec_count_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_f      = alu_f_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign exec_count = exec_count_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl: a 16-bit-counter DUT and a 2-bit-counter DUT run the same
// command stream against a simple add/sub ALU model.
module tb_alu_cmd_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_f;
    logic [1:0]  cmd_rd, cmd_rs1, cmd_rs2;
    logic [31:0] cmd_imm;
    logic        rsp_ready;

    logic        cmd_ready, rsp_valid;
    logic [31:0] rsp_data, alu_a, alu_b, alu_r;
    logic [3:0]  alu_f;
    logic [15:0] exec_count;

    logic        cmd_ready_s, rsp_valid_s;
    logic [31:0] rsp_data_s, alu_a_s, alu_b_s, alu_r_s;
    logic [3:0]  alu_f_s;
    logic [1:0]  exec_count_s;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] f);
        case (f)
            4'd0:    return a + b;
            4'd1:    return a - b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_r   = alu_model(alu_a, alu_b, alu_f);
    assign alu_r_s = alu_model(alu_a_s, alu_b_s, alu_f_s);

    alu_cmd_ctrl #(.W(32), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_f      (cmd_f),
        .cmd_rd     (cmd_rd),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .cmd_imm    (cmd_imm),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_f      (alu_f),
        .alu_r      (alu_r),
        .exec_count (exec_count)
    );

    alu_cmd_ctrl #(.W(32), .CNT_W(2)) dut_small (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready_s),
        .cmd_op     (cmd_op),
        .cmd_f      (cmd_f),
        .cmd_rd     (cmd_rd),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .cmd_imm    (cmd_imm),
        .rsp_valid  (rsp_valid_s),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data_s),
        .alu_a      (alu_a_s),
        .alu_b      (alu_b_s),
        .alu_f      (alu_f_s),
        .alu_r      (alu_r_s),
        .exec_count (exec_count_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Offer a command; returns #1 after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [3:0] f, input logic [1:0] rd,
                        input logic [1:0] rs1, input logic [1:0] rs2, input logic [31:0] imm);
        cmd_op = op; cmd_f = f; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) break;
            @(posedge clk); #1;
        end
        check("accept_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("ack_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("ack_cmd_ready", {30'd0, cmd_ready_s, cmd_ready}, 32'd3);
    endtask

    task automatic do_exec(input logic [3:0] f, input logic [1:0] rd, input logic [1:0] rs1,
                           input logic [1:0] rs2, input logic [31:0] exp);
        send(2'd1, f, rd, rs1, rs2, 32'd0);
        check("issue_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("issue_alu_f", {28'd0, alu_f}, {28'd0, f});
        @(posedge clk); #1;
        check("exec_rsp_valid", {30'd0, rsp_valid_s, rsp_valid}, 32'd3);
        check("exec_rsp_data", rsp_data, exp);
        check("exec_rsp_data_s", rsp_data_s, exp);
        ack();
    endtask

    task automatic do_read(input logic [1:0] rs1, input logic [31:0] exp);
        send(2'd2, 4'd0, 2'd0, rs1, 2'd0, 32'd0);
        check("read_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("read_rsp_data", rsp_data, exp);
        ack();
    endtask

    task automatic do_load(input logic [1:0] rd, input logic [31:0] imm);
        send(2'd0, 4'd0, rd, 2'd0, 2'd0, imm);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_f = '0; cmd_rd = '0;
        cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("por_cmd_ready_in_reset", {31'd0, cmd_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check("por_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("por_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("por_rsp_data", rsp_data, 32'd0);
        check("por_exec_count", {16'd0, exec_count}, 32'd0);

        // Registers are cleared by reset
        do_load(2'd0, 32'd7);
        do_load(2'd1, 32'd4);
        pulse_reset();
        do_read(2'd0, 32'd0);
        do_read(2'd1, 32'd0);
        check("rst_exec_count", {16'd0, exec_count}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_f", {28'd0, alu_f}, 32'd0);

        // Arithmetic
        do_load(2'd0, 32'd7);
        do_load(2'd1, 32'd4);
        do_exec(4'd0, 2'd2, 2'd0, 2'd1, 32'd11);
        check("arith_alu_a_held", alu_a, 32'd7);
        check("arith_alu_b_held", alu_b, 32'd4);
        do_exec(4'd1, 2'd3, 2'd0, 2'd1, 32'd3);
        do_read(2'd2, 32'd11);
        do_read(2'd3, 32'd3);
        check("arith_exec_count", {16'd0, exec_count}, 32'd2);

        // Backpressure: r1 = r2 + r3 = 14, response held while a LOAD is offered
        send(2'd1, 4'd0, 2'd1, 2'd2, 2'd3, 32'd0);
        @(posedge clk); #1;
        cmd_op = 2'd0; cmd_rd = 2'd0; cmd_imm = 32'h0000_DEAD; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_rsp_data", rsp_data, 32'd14);
            check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        ack();
        do_read(2'd0, 32'd7);
        do_read(2'd1, 32'd14);

        // Aliasing rd == rs1 == rs2
        do_load(2'd0, 32'hFFFF_FFFF);
        do_exec(4'd0, 2'd0, 2'd0, 2'd0, 32'hFFFF_FFFE);
        do_read(2'd0, 32'hFFFF_FFFE);
        check("alias_exec_count", {16'd0, exec_count}, 32'd4);

        // Reset during ISSUE aborts writeback
        send(2'd1, 4'd0, 2'd2, 2'd0, 2'd0, 32'd0);
        pulse_reset();
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_exec_count", {16'd0, exec_count}, 32'd0);
        @(posedge clk); #1;
        check("abort_rsp_valid_later", {31'd0, rsp_valid}, 32'd0);
        do_read(2'd2, 32'd0);

        // Counter wrap on the 2-bit instance; LOAD and NOP do not count
        do_load(2'd0, 32'd2);
        do_load(2'd1, 32'd3);
        do_exec(4'd0, 2'd2, 2'd0, 2'd1, 32'd5);
        send(2'd3, 4'd0, 2'd0, 2'd0, 2'd0, 32'd0);
        check("nop_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("nop_exec_count_s", {30'd0, exec_count_s}, 32'd1);
        do_exec(4'd1, 2'd3, 2'd2, 2'd0, 32'd3);
        do_load(2'd2, 32'd10);
        do_exec(4'd0, 2'd3, 2'd3, 2'd3, 32'd6);
        do_exec(4'd1, 2'd0, 2'd3, 2'd1, 32'd3);
        do_exec(4'd7, 2'd1, 2'd0, 2'd0, 32'd0);
        check("wrap_exec_count_s", {30'd0, exec_count_s}, 32'd1);
        check("wrap_exec_count", {16'd0, exec_count}, 32'd5);
        do_read(2'd2, 32'd10);
        do_read(2'd3, 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
- Sequential command front-end that drives the team's 32-bit combinational ALU (alu_new) from the initiator side.
- Accepts commands over a valid/ready interface and holds operands in a 4-entry x 32-bit register file.
- Issues one ALU operation at a time, writes the result back and returns it over a valid/ready response interface.
- Replaces hand-sequenced stimulus with a reusable controller for datapath integration.

Parameters:
- W, 32, data width of operands, ALU result and immediate.
- CNT_W, 16, width of executed-operation counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command
- cmd_op  input  2  0=LOAD, 1=EXEC, 2=READ, 3=NOP
- cmd_f  input  4  ALU function code, passed through unmodified on EXEC
- cmd_rd  input  2  destination register index
- cmd_rs1  input  2  source A index (EXEC), read index (READ)
- cmd_rs2  input  2  source B index
- cmd_imm  input  W  LOAD immediate
- rsp_valid  output  1  response data valid
- rsp_ready  input  1  consumer accepts response
- rsp_data  output  W  result / read data
- alu_a  output  W  to ALU operand a
- alu_b  output  W  to ALU operand b
- alu_f  output  4  to ALU function select
- alu_r  input  W  from ALU result r (combinational)
- exec_count  output  CNT_W  number of completed EXEC commands

Behaviour:
- Clock and reset are as decided: one clock (clk); reset is synchronous and active-high (reset).
- Reset, sampled at a clk edge, forces:
  - state=IDLE, all 4 registers=0
  - alu_a=0, alu_b=0, alu_f=0
  - rsp_valid=0, rsp_data=0, exec_count=0
  - cmd_ready=0 during the reset cycle, 1 in the first cycle after reset deasserts.
- Reset mid-operation aborts any EXEC or pending response; no writeback occurs.
- States: IDLE, ISSUE, RESP. cmd_ready = (state==IDLE) && !reset.
- Accept = cmd_valid && cmd_ready at a clk edge. Behaviour by cmd_op at the accepting edge:
  - LOAD: reg[cmd_rd] <= cmd_imm; state stays IDLE; no response; next command can be accepted the following cycle.
  - NOP: no state change, no response.
  - EXEC: alu_a <= reg[rs1], alu_b <= reg[rs2], alu_f <= cmd_f, latch rd; state -> ISSUE.
  - READ: rsp_data <= reg[rs1], rsp_valid <= 1; state -> RESP.
- ISSUE (exactly one cycle; gives the ALU a full cycle to settle) — at the end edge:
  - reg[rd] <= alu_r, rsp_data <= alu_r, rsp_valid <= 1
  - exec_count <= exec_count+1, wrapping modulo 2^CNT_W
  - state -> RESP.
- RESP: rsp_valid=1 and rsp_data held stable until rsp_valid && rsp_ready at an edge, then rsp_valid <= 0 and state -> IDLE. cmd_ready=0 throughout RESP (no overlap; one outstanding command max).
- Latency from accepting edge:
  - EXEC: rsp_valid high 2 edges later.
  - READ: rsp_valid high 1 edge later.
  - Minimum EXEC throughput: 1 per 3 cycles with rsp_ready tied high.
- alu_a/alu_b/alu_f are registered and hold their last values outside ISSUE.
- rd equal to rs1 or rs2 is legal: operands are captured at accept, and the writeback overwrites the register after use.
- cmd_f is never decoded; any 4-bit value is forwarded.
- rsp_ready is ignored when rsp_valid=0.
- cmd_* inputs are ignored when cmd_ready=0.

Test Plan:
- Bench ALU model is r=a+b for f=0 and r=a-b for f=1; the integration run also uses alu_new. The two rows below marked "model" assume this bench model.
- Reset (model): LOAD r0=7, r1=4, then assert reset for 1 cycle; READ r0 -> rsp_data=0; exec_count=0; alu_a=alu_b=alu_f=0.
- Arithmetic (model): LOAD r0=7, LOAD r1=4, EXEC f=0 rd=2 rs1=0 rs2=1 -> rsp_data=11 two edges after accept; EXEC f=1 rd=3 -> 3; READ r2 -> 11; exec_count=2.
- Backpressure: hold rsp_ready=0 for 5 cycles after EXEC -> rsp_valid stays 1, rsp_data stable, cmd_ready=0, a command offered meanwhile is not taken; release -> IDLE next cycle.
- Aliasing (model): r0=0xFFFFFFFF, EXEC f=0 rd=0 rs1=0 rs2=0 -> rsp_data=0xFFFFFFFE; READ r0 -> 0xFFFFFFFE.
- Reset mid-EXEC: assert reset during ISSUE -> no writeback to rd, rsp_valid=0, exec_count=0.
- Counter wrap: with CNT_W=2, run 5 EXECs -> exec_count=1; a NOP or LOAD between them does not increment.
